// File: rtl/noc_local_ni.sv
// ---------------------------------------------------------------------------
// noc_local_ni
//   Network interface between a processing element (PE) and the Local port
//   of a noc_router.
//
//   Inject path: a one-entry hold register takes a PE flit and forwards it to
//   the router. Forwarding is throttled by a registered write-enable that is
//   derived from the router's full/almost_full.
//   Eject path: router flits go into a first-word fall-through RX FIFO.
//   The FIFO returns full/almost_full to the router and presents its head to
//   the PE through a valid/ready handshake.
//
//   Flit format: [0] valid, [2:1] destination port, [WIDTH-1:3] payload.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   tx_valid/tx_ready                 PE inject handshake
//   tx_dst, tx_payload                PE destination code and payload
//   net_write, net_data               to router writeL / dataInL
//   net_full, net_almost_full         from router fullL / almost_fullL
//   rx_write, rx_data                 from router writeOutL / dataOutL
//   rx_full, rx_almost_full           to router readFullL / read_almostfullL
//   rx_valid/rx_ready                 PE eject handshake
//   rx_dst, rx_payload                head flit fields of the RX FIFO
//   rx_overflow                       sticky: valid flit dropped, FIFO full
//   rx_bad                            sticky: rx_write with flit bit0 = 0
//
// Optional build macro NOC_NI_STATS_EN
//   Adds parameter CNT_W and outputs tx_flits / rx_flits, which are
//   wrapping counts of flits sent to the router and pushed into the RX FIFO.
// ---------------------------------------------------------------------------
module noc_local_ni #(
    parameter int WIDTH    = 16,
    parameter int RX_DEPTH = 8
`ifdef NOC_NI_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [1:0]       tx_dst,
    input  logic [WIDTH-4:0] tx_payload,
    output logic             net_write,
    output logic [WIDTH-1:0] net_data,
    input  logic             net_full,
    input  logic             net_almost_full,
    input  logic             rx_write,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_full,
    output logic             rx_almost_full,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [1:0]       rx_dst,
    output logic [WIDTH-4:0] rx_payload,
    output logic             rx_overflow,
    output logic             rx_bad
`ifdef NOC_NI_STATS_EN
    ,
    output logic [CNT_W-1:0] tx_flits,
    output logic [CNT_W-1:0] rx_flits
`endif
);

    localparam int          AW      = $clog2(RX_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(RX_DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(RX_DEPTH - 1);

    // ------------------------------------------------------------------ TX
    logic             r_wr_able;
    logic             r_hold_v;
    logic [WIDTH-1:0] r_hold_flit;
    logic             r_net_write;
    logic [WIDTH-1:0] r_net_data;
    logic             w_accept;
    logic             w_send;

    // The hold slot can take a new flit when it is empty, or when its current
    // flit leaves on this same edge.
    assign tx_ready  = !reset & (!r_hold_v | r_wr_able);
    assign w_accept  = tx_valid & tx_ready;
    assign w_send    = r_hold_v & r_wr_able;
    assign net_write = r_net_write;
    assign net_data  = r_net_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; w_send here sees the old r_hold_v/r_wr_able.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_able   <= 1'b0;
            r_hold_v    <= 1'b0;
            r_hold_flit <= '0;
            r_net_write <= 1'b0;
            r_net_data  <= '0;
        end else begin
            // Our own last write counts against an almost-full router.
            r_wr_able <= !((net_almost_full & r_net_write) | net_full);
            if (w_accept) begin
                r_hold_v    <= 1'b1;
                r_hold_flit <= {tx_payload, tx_dst, 1'b1};
            end else if (w_send) begin
                r_hold_v <= 1'b0;
            end
            r_net_write <= w_send;
            r_net_data  <= w_send ? r_hold_flit : '0;
        end
    end

    // ------------------------------------------------------------------ RX
    // Stored entries always carry bit0 = 1, so only [WIDTH-1:1] is kept.
    logic [WIDTH-2:0] r_mem [RX_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_rx_full;
    logic             r_rx_afull;
    logic             r_overflow;
    logic             r_bad;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic             w_bad_flit;
    logic [WIDTH-2:0] w_head;

    assign w_pop       = (r_count != '0) & rx_ready;
    assign w_full      = (r_count == DEPTH_C);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds when the PE is draining.
    assign w_push      = rx_write & rx_data[0] & (!w_full | w_pop);
    assign w_drop      = rx_write & rx_data[0] & w_full & !w_pop;
    assign w_bad_flit  = rx_write & !rx_data[0];
    assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    assign w_head         = r_mem[r_rd_ptr];
    assign rx_valid       = (r_count != '0);
    assign rx_dst         = w_head[1:0];
    assign rx_payload     = w_head[WIDTH-2:2];
    assign rx_full        = r_rx_full;
    assign rx_almost_full = r_rx_afull;
    assign rx_overflow    = r_overflow;
    assign rx_bad         = r_bad;

    // NOTE: the FIFO storage has no reset; emptiness is tracked by r_count,
    // so stale words are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rx_full  <= 1'b0;
            r_rx_afull <= 1'b0;
            r_overflow <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nxt;
            r_rx_full  <= (w_count_nxt == DEPTH_C);
            r_rx_afull <= (w_count_nxt >= AFULL_C);
            if (w_drop)     r_overflow <= 1'b1;
            if (w_bad_flit) r_bad      <= 1'b1;
        end
    end

`ifdef NOC_NI_STATS_EN
    // --------------------------------------------------------------- stats
    logic [CNT_W-1:0] r_tx_flits;
    logic [CNT_W-1:0] r_rx_flits;

    assign tx_flits = r_tx_flits;
    assign rx_flits = r_rx_flits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_flits <= '0;
            r_rx_flits <= '0;
        end else begin
            if (w_send) r_tx_flits <= r_tx_flits + 1'b1;
            if (w_push) r_rx_flits <= r_rx_flits + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// ---------------------------------------------------------------------------
// tb_noc_local_ni
//   Self-checking bench for noc_local_ni. A transaction-level reference model
//   keeps the hold slot and RX FIFO as queues and predicts every output each
//   cycle. Directed phases follow the inject/eject scenarios; a randomized
//   phase follows them.
// ---------------------------------------------------------------------------
module tb_noc_local_ni;

    localparam int WIDTH = 16;
    localparam int PW    = WIDTH - 3;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             tx_valid;
    logic             tx_ready;
    logic [1:0]       tx_dst;
    logic [PW-1:0]    tx_payload;
    logic             net_write;
    logic [WIDTH-1:0] net_data;
    logic             net_full;
    logic             net_almost_full;
    logic             rx_write;
    logic [WIDTH-1:0] rx_data;
    logic             rx_full;
    logic             rx_almost_full;
    logic             rx_valid;
    logic             rx_ready;
    logic [1:0]       rx_dst;
    logic [PW-1:0]    rx_payload;
    logic             rx_overflow;
    logic             rx_bad;
`ifdef NOC_NI_STATS_EN
    logic [15:0]      tx_flits;
    logic [15:0]      rx_flits;
`endif

    always #5 clk = ~clk;

    noc_local_ni #(.WIDTH(WIDTH), .RX_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_dst         (tx_dst),
        .tx_payload     (tx_payload),
        .net_write      (net_write),
        .net_data       (net_data),
        .net_full       (net_full),
        .net_almost_full(net_almost_full),
        .rx_write       (rx_write),
        .rx_data        (rx_data),
        .rx_full        (rx_full),
        .rx_almost_full (rx_almost_full),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_dst         (rx_dst),
        .rx_payload     (rx_payload),
        .rx_overflow    (rx_overflow),
        .rx_bad         (rx_bad)
`ifdef NOC_NI_STATS_EN
        ,
        .tx_flits       (tx_flits),
        .rx_flits       (rx_flits)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- reference model
    bit               m_wr_able;
    bit               m_net_write;
    logic [WIDTH-1:0] m_net_data;
    logic [WIDTH-1:0] m_hold[$];
    logic [WIDTH-1:0] m_rx[$];
    bit               m_ovf;
    bit               m_bad;
    bit               m_accepted;
    int unsigned      m_tx_cnt;
    int unsigned      m_rx_cnt;

    task automatic model_clear();
        m_wr_able   = 1'b0;
        m_net_write = 1'b0;
        m_net_data  = '0;
        m_hold.delete();
        m_rx.delete();
        m_ovf       = 1'b0;
        m_bad       = 1'b0;
        m_accepted  = 1'b0;
        m_tx_cnt    = 0;
        m_rx_cnt    = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, then leave
    // the caller just after the rising edge to change inputs.
    task automatic cycle();
        bit               exp_ready;
        bit               accept;
        bit               send;
        logic [WIDTH-1:0] head;
        @(negedge clk);
        exp_ready = (m_hold.size() == 0) || m_wr_able;
        check("tx_ready", tx_ready, exp_ready);
        check("net_write", net_write, m_net_write);
        check("net_data", net_data, m_net_data);
        check("rx_valid", rx_valid, m_rx.size() != 0);
        if (m_rx.size() != 0) begin
            head = m_rx[0];
            check("rx_dst", rx_dst, head[2:1]);
            check("rx_payload", rx_payload, head[WIDTH-1:3]);
        end
        check("rx_full", rx_full, m_rx.size() == DEPTH);
        check("rx_almost_full", rx_almost_full, m_rx.size() >= DEPTH - 1);
        check("rx_overflow", rx_overflow, m_ovf);
        check("rx_bad", rx_bad, m_bad);
`ifdef NOC_NI_STATS_EN
        check("tx_flits", tx_flits, m_tx_cnt[15:0]);
        check("rx_flits", rx_flits, m_rx_cnt[15:0]);
`endif
        accept    = tx_valid && exp_ready;
        send      = (m_hold.size() != 0) && m_wr_able;
        m_wr_able = !((net_almost_full && m_net_write) || net_full);
        m_net_write = send;
        m_net_data  = send ? m_hold.pop_front() : '0;
        if (send) m_tx_cnt++;
        if (accept) m_hold.push_back({tx_payload, tx_dst, 1'b1});
        m_accepted = accept;
        if ((m_rx.size() != 0) && rx_ready) void'(m_rx.pop_front());
        if (rx_write) begin
            if (!rx_data[0]) m_bad = 1'b1;
            else if (m_rx.size() < DEPTH) begin
                m_rx.push_back(rx_data);
                m_rx_cnt++;
            end else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tx_valid = 0; tx_dst = 0; tx_payload = 0;
        net_full = 0; net_almost_full = 0;
        rx_write = 0; rx_data = 0; rx_ready = 0;
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset(input int cycles);
        #2 reset = 1'b1;
        #1;
        check("rst_net_write", net_write, 0);
        check("rst_net_data", net_data, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_full", rx_full, 0);
        check("rst_rx_almost_full", rx_almost_full, 0);
        check("rst_rx_overflow", rx_overflow, 0);
        check("rst_rx_bad", rx_bad, 0);
`ifdef NOC_NI_STATS_EN
        check("rst_tx_flits", tx_flits, 0);
        check("rst_rx_flits", rx_flits, 0);
`endif
        model_clear();
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_flit(input logic [1:0] d, input logic [PW-1:0] p);
        tx_valid = 1; tx_dst = d; tx_payload = p;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (m_accepted) break;
        end
        check("tx_accept_budget", m_accepted, 1);
        tx_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int nf;
        int sent;
        bit started;
        reset = 1'b1;
        idle_inputs();
        model_clear();
        do_reset(3);

        // Basic inject: dst 01, payload 0x0AB -> flit 0x055B
        cycle();
        tx_valid = 1; tx_dst = 2'b01; tx_payload = 13'h0AB;
        cycle();
        tx_valid = 0;
        cycle();
        check("basic_net_write", net_write, 1);
        check("basic_net_data", net_data, 16'h055B);
        cycle();
        cycle();

        // Backpressure: 4 flits, net_full for 3 cycles once flit 3 is up
        idx = 0; nf = 0; sent = 0; started = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 4) begin
                tx_valid = 1; tx_dst = 2'(idx); tx_payload = 13'h100 + 13'(idx);
            end else tx_valid = 0;
            if (idx >= 2 && !started) begin started = 1; nf = 3; end
            net_full = (nf > 0);
            if (nf > 0) nf--;
            cycle();
            if (m_accepted) idx++;
            if (net_write) sent++;
        end
        net_full = 0;
        check("bp_sent_count", sent, 4);

        // Almost-full: writes alternate with stalls
        net_almost_full = 1;
        for (int i = 0; i < 4; i++) send_flit(2'b11, 13'h0A0 + 13'(i));
        repeat (4) cycle();
        net_almost_full = 0;

        // Eject fill: 9 pushes into an 8-deep FIFO with no PE pops
        rx_ready = 0;
        for (int i = 0; i < 9; i++) begin
            rx_write = 1;
            rx_data  = {13'h1C0 + 13'(i), 2'(i), 1'b1};
            cycle();
        end
        rx_write = 0;
        cycle();
        check("fill_overflow", rx_overflow, 1);
        check("fill_full", rx_full, 1);

        // Drain in order
        rx_ready = 1;
        repeat (10) cycle();
        rx_ready = 0;

        // Bad flit, then reset mid-stream
        rx_write = 1; rx_data = 16'h0004;
        cycle();
        rx_write = 1; rx_data = 16'h1235;
        tx_valid = 1; tx_dst = 2'b10; tx_payload = 13'h0777;
        cycle();
        cycle();
        do_reset(2);
        idle_inputs();
        repeat (3) cycle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tx_valid        = ($urandom_range(0, 9) < 7);
            tx_dst          = 2'($urandom);
            tx_payload      = PW'($urandom);
            net_full        = ($urandom_range(0, 9) < 2);
            net_almost_full = ($urandom_range(0, 9) < 3);
            rx_write        = ($urandom_range(0, 9) < 6);
            rx_data         = {WIDTH-1{1'b0}} | WIDTH'($urandom);
            if ($urandom_range(0, 9) != 0) rx_data[0] = 1'b1;
            rx_ready        = ($urandom_range(0, 9) < (c < 1500 ? 4 : 7));
            if ($urandom_range(0, 599) == 0) do_reset(1);
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
